seq_detector_prog: RTL and testbench

Runtime-programmable serial pattern detector. It is the parametrised successor of the fixed 3-bit "101" detector. Pattern length (1..MAX_LEN), pattern bits and overlap/non-overlap mode are loaded through a config strobe. A saturating match counter drives an active-low 7-segment hex display of the count. It sits between a serial input sampler and the board display/status logic.

---
 rtl/seq_det_pkg.sv | 29 ++
 rtl/seq_detector_prog_if.sv | 28 ++
 rtl/seq_detector_prog_hex_to_seg7.sv | 31 +++
 rtl/seq_detector_prog.sv | 117 +++++++++++
 tb/tb_seq_detector_prog.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants for the programmable sequence detector: active-low
// 7-segment hex glyphs and the power-up detector configuration.
package seq_det_pkg;

  // {g,f,e,d,c,b,a}, segment lit when 0
  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Power-up behaviour matches the legacy fixed "101" overlapping detector
  localparam int   DEF_PATTERN = 5;
  localparam int   DEF_LEN     = 3;
  localparam logic DEF_OVERLAP = 1'b1;

endpackage

// File: rtl/seq_detector_prog_if.sv
// Serial data, configuration and status bundle of the sequence detector.
interface seq_detector_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic               serial_in;
  logic               in_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               detected;
  logic [CNT_W-1:0]   match_count;
  logic               count_sat;
  logic               cfg_err;
  logic [6:0]         seg_out;

  modport master (
    output serial_in, in_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    input  detected, match_count, count_sat, cfg_err, seg_out
  );

  modport slave (
    input  serial_in, in_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    output detected, match_count, count_sat, cfg_err, seg_out
  );
endinterface

// File: rtl/seq_detector_prog_hex_to_seg7.sv
// Combinational hex digit to active-low 7-segment decoder.
module hex_to_seg7
  import seq_det_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (hex)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with a saturating match
// counter shown on an active-low 7-segment hex digit.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  seq_detector_prog_if.slave bus
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [MAX_LEN-1:0] act_pattern, act_pattern_n;
  logic [LEN_W-1:0]   act_len, act_len_n;
  logic               act_overlap, act_overlap_n;
  logic [MAX_LEN-1:0] history, history_n, hist_shift;
  logic [LEN_W-1:0]   bits_seen, bits_seen_n, seen_inc;
  logic               detected_q, detected_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               sat_q, sat_n;
  logic               err_q, err_n;
  logic [6:0]         seg_q, seg_n;
  logic               cfg_ok, match;

  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [MAX_LEN-1:0] m;
    for (int i = 0; i < MAX_LEN; i++) m[i] = (i < int'(len));
    return m;
  endfunction

  always_comb begin
    hist_shift = {history[MAX_LEN-2:0], bus.serial_in};
    seen_inc   = (bits_seen == MAX_LEN_V) ? bits_seen : bits_seen + 1'b1;
    cfg_ok     = (bus.cfg_len != '0) && (bus.cfg_len <= MAX_LEN_V);
    // bits_seen gate stops a match against zero-filled history after a clear
    match      = (seen_inc >= act_len) &&
                 ((hist_shift & len_mask(act_len)) == act_pattern);
  end

  always_comb begin
    act_pattern_n = act_pattern;
    act_len_n     = act_len;
    act_overlap_n = act_overlap;
    history_n     = history;
    bits_seen_n   = bits_seen;
    detected_n    = 1'b0;
    cnt_n         = cnt_q;
    sat_n         = sat_q;
    err_n         = err_q;

    if (bus.cfg_load) begin
      history_n   = '0;
      bits_seen_n = '0;
      cnt_n       = '0;
      sat_n       = 1'b0;
      err_n       = !cfg_ok;
      if (cfg_ok) begin
        act_pattern_n = bus.cfg_pattern & len_mask(bus.cfg_len);
        act_len_n     = bus.cfg_len;
        act_overlap_n = bus.cfg_overlap;
      end
    end else if (bus.in_valid) begin
      history_n   = hist_shift;
      bits_seen_n = seen_inc;
      if (match) begin
        detected_n = 1'b1;
        if (cnt_q != CNT_MAX) cnt_n = cnt_q + 1'b1;
        if (!act_overlap) bits_seen_n = '0;
      end
      sat_n = sat_q | (cnt_n == CNT_MAX);
    end
  end

  // Decode the next count so the display lands in the same edge as the count
  hex_to_seg7 u_hex_to_seg7 (
    .hex (cnt_n[3:0]),
    .seg (seg_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_pattern <= MAX_LEN'(DEF_PATTERN);
      act_len     <= LEN_W'(DEF_LEN);
      act_overlap <= DEF_OVERLAP;
      history     <= '0;
      bits_seen   <= '0;
      detected_q  <= 1'b0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      err_q       <= 1'b0;
      seg_q       <= SEG_HEX_0;
    end else begin
      act_pattern <= act_pattern_n;
      act_len     <= act_len_n;
      act_overlap <= act_overlap_n;
      history     <= history_n;
      bits_seen   <= bits_seen_n;
      detected_q  <= detected_n;
      cnt_q       <= cnt_n;
      sat_q       <= sat_n;
      err_q       <= err_n;
      seg_q       <= seg_n;
    end
  end

  assign bus.detected    = detected_q;
  assign bus.match_count = cnt_q;
  assign bus.count_sat   = sat_q;
  assign bus.cfg_err     = err_q;
  assign bus.seg_out     = seg_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Bench for seq_detector_prog: two instances (8-bit and 4-bit counters) share
// stimulus; a bit-queue model feeds a scoreboard checked after every edge.
module tb_seq_detector_prog;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_detector_prog_if #(.MAX_LEN(8), .CNT_W(8)) bus8 ();
  seq_detector_prog_if #(.MAX_LEN(8), .CNT_W(4)) bus4 ();

  seq_detector_prog #(.MAX_LEN(8), .CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  seq_detector_prog #(.MAX_LEN(8), .CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  typedef struct packed {
    logic       det;
    logic [7:0] c8;
    logic [3:0] c4;
    logic       s8;
    logic       s4;
    logic       err;
    logic [6:0] g8;
    logic [6:0] g4;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // reference model state
  logic       m_bits[$];
  logic [7:0] m_pat;
  int         m_len;
  logic       m_ovl;
  logic [7:0] m_c8;
  logic [3:0] m_c4;
  logic       m_s8, m_s4, m_err;

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_pat = 8'b101; m_len = 3; m_ovl = 1'b1;
    m_c8 = '0; m_c4 = '0; m_s8 = 1'b0; m_s4 = 1'b0; m_err = 1'b0;
  endtask

  task automatic step(input logic b, input logic v, input logic ld,
                      input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    exp_t e;
    logic det;
    bus8.serial_in = b; bus8.in_valid = v; bus8.cfg_load = ld;
    bus8.cfg_pattern = pat; bus8.cfg_len = len; bus8.cfg_overlap = ovl;
    bus4.serial_in = b; bus4.in_valid = v; bus4.cfg_load = ld;
    bus4.cfg_pattern = pat; bus4.cfg_len = len; bus4.cfg_overlap = ovl;
    det = 1'b0;
    if (ld) begin
      if (len >= 1 && len <= 8) begin
        m_pat = pat; m_len = int'(len); m_ovl = ovl; m_err = 1'b0;
      end else m_err = 1'b1;
      m_bits.delete();
      m_c8 = '0; m_c4 = '0; m_s8 = 1'b0; m_s4 = 1'b0;
    end else if (v) begin
      m_bits.push_back(b);
      if (m_bits.size() > 8) void'(m_bits.pop_front());
      if (m_bits.size() >= m_len) begin
        det = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) det = 1'b0;
      end
      if (det) begin
        if (m_c8 != 8'hFF) m_c8 = m_c8 + 1'b1;
        if (m_c4 != 4'hF) m_c4 = m_c4 + 1'b1;
        if (!m_ovl) m_bits.delete();
      end
      if (m_c8 == 8'hFF) m_s8 = 1'b1;
      if (m_c4 == 4'hF) m_s4 = 1'b1;
    end
    e = '{det: det, c8: m_c8, c4: m_c4, s8: m_s8, s4: m_s4, err: m_err,
          g8: seg_ref(m_c8[3:0]), g4: seg_ref(m_c4)};
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic bit_in(input logic b);
    step(b, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
  endtask

  task automatic gap();
    step(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    step(1'b0, 1'b0, 1'b1, pat, len, ovl);
  endtask

  // Scoreboard: every driven cycle pushed one expectation
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      n_cmp++;
      if (bus8.detected !== mon_e.det || bus4.detected !== mon_e.det) begin
        n_fail++;
        $display("FAIL sb_detected t=%0t got %b/%b exp %b", $time, bus8.detected, bus4.detected, mon_e.det);
      end
      n_cmp++;
      if (bus8.match_count !== mon_e.c8) begin
        n_fail++;
        $display("FAIL sb_count8 t=%0t got %0d exp %0d", $time, bus8.match_count, mon_e.c8);
      end
      n_cmp++;
      if (bus4.match_count !== mon_e.c4) begin
        n_fail++;
        $display("FAIL sb_count4 t=%0t got %0d exp %0d", $time, bus4.match_count, mon_e.c4);
      end
      n_cmp++;
      if (bus8.count_sat !== mon_e.s8 || bus4.count_sat !== mon_e.s4) begin
        n_fail++;
        $display("FAIL sb_sat t=%0t got %b/%b exp %b/%b", $time, bus8.count_sat, bus4.count_sat, mon_e.s8, mon_e.s4);
      end
      n_cmp++;
      if (bus8.cfg_err !== mon_e.err || bus4.cfg_err !== mon_e.err) begin
        n_fail++;
        $display("FAIL sb_cfg_err t=%0t got %b/%b exp %b", $time, bus8.cfg_err, bus4.cfg_err, mon_e.err);
      end
      n_cmp++;
      if (bus8.seg_out !== mon_e.g8 || bus4.seg_out !== mon_e.g4) begin
        n_fail++;
        $display("FAIL sb_seg t=%0t got %b/%b exp %b/%b", $time, bus8.seg_out, bus4.seg_out, mon_e.g8, mon_e.g4);
      end
    end
  end

  task automatic test_reset();
    n_cmp++;
    if (bus8.detected !== 1'b0 || bus8.match_count !== 8'd0 || bus8.count_sat !== 1'b0 ||
        bus8.cfg_err !== 1'b0 || bus8.seg_out !== 7'b1000000 || bus4.match_count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_values got det=%b cnt=%0d sat=%b err=%b seg=%b", bus8.detected,
               bus8.match_count, bus8.count_sat, bus8.cfg_err, bus8.seg_out);
    end
  endtask

  task automatic test_default_overlap();
    logic [4:0] bits = 5'b10101;
    logic [4:0] dets;
    for (int i = 4; i >= 0; i--) begin
      bit_in(bits[i]);
      dets[i] = bus8.detected;
    end
    n_cmp++;
    if (dets !== 5'b00101) begin
      n_fail++;
      $display("FAIL overlap_pulses got %b exp 00101", dets);
    end
    n_cmp++;
    if (bus8.match_count !== 8'd2 || bus8.seg_out !== 7'b0100100) begin
      n_fail++;
      $display("FAIL overlap_count got %0d seg %b exp 2 seg 0100100", bus8.match_count, bus8.seg_out);
    end
  endtask

  task automatic test_nonoverlap();
    logic [7:0] bits = 8'b10101101;
    logic [7:0] dets;
    load(8'b101, 4'd3, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      bit_in(bits[i]);
      dets[i] = bus8.detected;
    end
    n_cmp++;
    if (dets !== 8'b00100001) begin
      n_fail++;
      $display("FAIL nonoverlap_pulses got %b exp 00100001", dets);
    end
    n_cmp++;
    if (bus8.match_count !== 8'd2) begin
      n_fail++;
      $display("FAIL nonoverlap_count got %0d exp 2", bus8.match_count);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] p = 8'hA5;
    int pulses = 0;
    int gap_pulses = 0;
    logic last_hit = 1'b0;
    load(p, 4'd8, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      bit_in(p[i]);
      if (bus8.detected) pulses++;
      if (i == 0) last_hit = bus8.detected;
      gap();
      if (bus8.detected) gap_pulses++;
    end
    n_cmp++;
    if (pulses !== 1 || last_hit !== 1'b1 || gap_pulses !== 0) begin
      n_fail++;
      $display("FAIL gap_pulses got %0d last=%b gaps=%0d exp 1 1 0", pulses, last_hit, gap_pulses);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    load(8'hFF, 4'd8, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      bit_in(1'b1);
      if (bus8.detected) pulses++;
      if (i == 7) begin
        n_cmp++;
        if (pulses !== 0) begin
          n_fail++;
          $display("FAIL len8_early got %0d pulses exp 0", pulses);
        end
      end
    end
    n_cmp++;
    if (pulses !== 3 || bus8.match_count !== 8'd3) begin
      n_fail++;
      $display("FAIL len8_b2b got %0d pulses cnt %0d exp 3 3", pulses, bus8.match_count);
    end
  endtask

  task automatic test_saturate();
    load(8'h03, 4'd1, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      bit_in(1'b1);
      n_cmp++;
      if (bus4.count_sat !== (i >= 15) || bus4.detected !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_flag i=%0d got sat=%b det=%b", i, bus4.count_sat, bus4.detected);
      end
    end
    n_cmp++;
    if (bus4.match_count !== 4'hF || bus4.seg_out !== 7'b0001110 ||
        bus8.match_count !== 8'd17 || bus8.count_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_final got c4=%0d seg=%b c8=%0d s8=%b", bus4.match_count, bus4.seg_out,
               bus8.match_count, bus8.count_sat);
    end
    load(8'h01, 4'd1, 1'b1);
    n_cmp++;
    if (bus4.match_count !== 4'd0 || bus4.count_sat !== 1'b0 || bus4.seg_out !== 7'b1000000) begin
      n_fail++;
      $display("FAIL sat_clear got c4=%0d sat=%b", bus4.match_count, bus4.count_sat);
    end
  endtask

  task automatic test_bad_cfg();
    load(8'b110, 4'd3, 1'b1);
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b0);
    step(1'b1, 1'b1, 1'b1, 8'h00, 4'd0, 1'b1);
    n_cmp++;
    if (bus8.cfg_err !== 1'b1 || bus8.match_count !== 8'd0 || bus8.detected !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_len0 got err=%b cnt=%0d det=%b", bus8.cfg_err, bus8.match_count, bus8.detected);
    end
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b0);
    n_cmp++;
    if (bus8.detected !== 1'b1 || bus8.cfg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL old_pattern got det=%b err=%b exp 1 1", bus8.detected, bus8.cfg_err);
    end
    load(8'h00, 4'd9, 1'b1);
    load(8'hFD, 4'd1, 1'b1);
    n_cmp++;
    if (bus8.cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear got %b exp 0", bus8.cfg_err);
    end
    step(1'b1, 1'b1, 1'b1, 8'h01, 4'd1, 1'b1);
    n_cmp++;
    if (bus8.detected !== 1'b0 || bus8.match_count !== 8'd0) begin
      n_fail++;
      $display("FAIL load_drops_bit got det=%b cnt=%0d exp 0 0", bus8.detected, bus8.match_count);
    end
  endtask

  task automatic test_rst_mid();
    load(8'b101, 4'd3, 1'b1);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b0);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus8.match_count !== 8'd0 || bus8.seg_out !== 7'b1000000 || bus8.detected !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst got cnt=%0d seg=%b det=%b", bus8.match_count, bus8.seg_out, bus8.detected);
    end
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    bit_in(1'b1);
    n_cmp++;
    if (bus8.detected !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_lost_history got det=%b exp 0", bus8.detected);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus8.serial_in = 0; bus8.in_valid = 0; bus8.cfg_load = 0;
    bus8.cfg_pattern = '0; bus8.cfg_len = '0; bus8.cfg_overlap = 0;
    bus4.serial_in = 0; bus4.in_valid = 0; bus4.cfg_load = 0;
    bus4.cfg_pattern = '0; bus4.cfg_len = '0; bus4.cfg_overlap = 0;
    model_reset();
    #12;
    test_reset();
    rst = 1'b0;
    @(posedge clk);
    #2;
    test_default_overlap();
    test_nonoverlap();
    test_gaps();
    test_back_to_back();
    test_saturate();
    test_bad_cfg();
    test_rst_mid();
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got %0d pending exp 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
